lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter POLY_WIDTH, default 84, LFSR state width (64 < POLY_WIDTH <= 96).
REQ-002 SHALL have parameter BASE_ADDR, default 12'h0a9, address of seed word 0; words 1 and 2 at BASE_ADDR+1 and BASE_ADDR+2.
REQ-003 SHALL have parameter CNT_W, default 16, block-counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a keystream run.
REQ-007 SHALL have port abort  input  1  terminate the current run.
REQ-008 SHALL have port seed  input  POLY_WIDTH  seed, sampled on an accepted start.
REQ-009 SHALL have port num_blocks  input  CNT_W  number of keystream blocks, sampled on an accepted start.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-012 SHALL have port lfsr_write  output  1  LFSR register-bus write strobe.
REQ-013 SHALL have port lfsr_addr  output  12  LFSR register-bus address.
REQ-014 SHALL have port lfsr_din  output  32  LFSR register-bus write data.
REQ-015 SHALL have port lfsr_enable  output  1  LFSR advance strobe (one multi-step advance per cycle).
REQ-016 SHALL have port lfsr_dout  input  POLY_WIDTH  current LFSR state.
REQ-017 SHALL have port ks_valid  output  1  keystream block available.
REQ-018 SHALL have port ks_ready  input  1  downstream accepts block.
REQ-019 SHALL have port ks_data  output  POLY_WIDTH  keystream block, equal to lfsr_dout.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD0, LOAD1, LOAD2, PRIME, RUN, DONE.
REQ-021 IDLE: start=1 with num_blocks!=0 SHALL latch seed and num_blocks into internal registers and go to LOAD0; start=1 with num_blocks==0 SHALL go directly to DONE with no bus writes.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 LOAD0/LOAD1/LOAD2 SHALL each last one cycle, drive lfsr_write=1 and lfsr_addr=BASE_ADDR+0/+1/+2, and drive lfsr_din = seed[31:0] / seed[63:32] / seed[POLY_WIDTH-1:64] zero-extended to 32 bits.
REQ-024 lfsr_enable SHALL be 0 in all LOADx states, because the LFSR prioritises enable over load.
REQ-025 PRIME SHALL last one cycle with lfsr_enable=1 and lfsr_write=0; the first keystream block is the seed advanced once.
REQ-026 RUN: ks_valid SHALL be 1, ks_data SHALL be lfsr_dout, and lfsr_enable SHALL be ks_valid & ks_ready (combinational).
REQ-027 Each RUN cycle with ks_ready=1 SHALL decrement the remaining count by 1; the handshake on the block with count==1 SHALL move the FSM to DONE.
REQ-028 ks_valid=1 SHALL NOT be withdrawn, and ks_data SHALL NOT change, until handshake, except on abort or reset.
REQ-029 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL move the FSM to IDLE next cycle with no done pulse; during that cycle lfsr_write, lfsr_enable and ks_valid SHALL all be 0.
REQ-031 abort and start asserted together in IDLE: abort SHALL win and the start SHALL be dropped.
REQ-032 Outside LOADx: lfsr_write=0, lfsr_addr=0 and lfsr_din=0.
REQ-033 Outside RUN: ks_valid=0. lfsr_enable=0 in all states except PRIME and RUN.
REQ-034 Total blocks delivered per run SHALL equal the latched num_blocks; num_blocks=2^CNT_W-1 SHALL be supported without counter wrap.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE and clear the count, seed and num_blocks latches.
REQ-036 During reset, busy, done, lfsr_write, lfsr_enable and ks_valid SHALL be 0, and lfsr_addr and lfsr_din SHALL be 0.
REQ-037 Reset asserted mid-run SHALL discard the run; after release the block stays in IDLE until a new start.

Verification
REQ-038 Basic run: seed=84'h1, num_blocks=3, ks_ready=1 -> writes at 0x0a9/0x0aa/0x0ab with data 0x1/0x0/0x0, then one PRIME enable, then 3 blocks matching a golden LFSR model, then done one cycle; total busy = 8 cycles.
REQ-039 Backpressure: num_blocks=2, ks_ready low for 5 RUN cycles -> ks_data stable and lfsr_enable=0 throughout, then exactly 2 handshakes.
REQ-040 Zero length: start with num_blocks=0 -> busy for 1 cycle, done=1, no lfsr_write, no lfsr_enable.
REQ-041 Abort: abort in LOAD1 -> IDLE next cycle, no done, no further writes; abort in RUN after 1 of 4 blocks -> ks_valid drops, exactly 1 block delivered.
REQ-042 start asserted while busy -> ignored, and seed/num_blocks latches unchanged.
REQ-043 Reset pulse during RUN -> all outputs 0 immediately (asynchronous), FSM in IDLE after rst_n release.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external LFSR: loads a seed over a 32-bit register bus,
// primes one advance, then streams num_blocks keystream blocks with ready/valid.
module lfsr_seq_ctrl #(
  parameter int          POLY_WIDTH = 84,
  parameter logic [11:0] BASE_ADDR  = 12'h0a9,
  parameter int          CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [POLY_WIDTH-1:0] seed,
  input  logic [CNT_W-1:0]      num_blocks,
  output logic                  busy,
  output logic                  done,
  output logic                  lfsr_write,
  output logic [11:0]           lfsr_addr,
  output logic [31:0]           lfsr_din,
  output logic                  lfsr_enable,
  input  logic [POLY_WIDTH-1:0] lfsr_dout,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [POLY_WIDTH-1:0] ks_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_LOAD2 = 3'd3,
    S_PRIME = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      nblk_q;
  logic [POLY_WIDTH-1:0] seed_q;
  logic [95:0]           seed_ext;

  // Upper seed word is zero-extended to the full 32-bit bus width.
  assign seed_ext = 96'(seed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nblk_q  <= '0;
      seed_q  <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_blocks != '0) begin
              seed_q  <= seed;
              nblk_q  <= num_blocks;
              state_q <= S_LOAD0;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_LOAD0: state_q <= S_LOAD1;
        S_LOAD1: state_q <= S_LOAD2;
        S_LOAD2: state_q <= S_PRIME;
        S_PRIME: begin
          cnt_q   <= nblk_q;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (ks_ready) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign ks_data = lfsr_dout;

  // Strobes are decoded from the registered state and gated by abort so an
  // aborting cycle never writes, advances or presents a block.
  always_comb begin
    lfsr_write  = 1'b0;
    lfsr_addr   = '0;
    lfsr_din    = '0;
    lfsr_enable = 1'b0;
    ks_valid    = 1'b0;
    done        = 1'b0;
    if (!abort) begin
      case (state_q)
        S_LOAD0: begin
          lfsr_write = 1'b1;
          lfsr_addr  = BASE_ADDR;
          lfsr_din   = seed_ext[31:0];
        end
        S_LOAD1: begin
          lfsr_write = 1'b1;
          lfsr_addr  = BASE_ADDR + 12'd1;
          lfsr_din   = seed_ext[63:32];
        end
        S_LOAD2: begin
          lfsr_write = 1'b1;
          lfsr_addr  = BASE_ADDR + 12'd2;
          lfsr_din   = seed_ext[95:64];
        end
        S_PRIME: lfsr_enable = 1'b1;
        S_RUN: begin
          ks_valid    = 1'b1;
          lfsr_enable = ks_ready;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a behavioural LFSR device on the bus, table-driven
// runs, hand-written abort/reset sequences and randomized runs.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [83:0] seed = '0;
  logic [15:0] num_blocks = '0;
  logic        busy, done, lfsr_write, lfsr_enable, ks_valid;
  logic [11:0] lfsr_addr;
  logic [31:0] lfsr_din;
  logic [83:0] lfsr_dout, ks_data;
  logic        ks_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  lfsr_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_blocks(num_blocks), .busy(busy), .done(done), .lfsr_write(lfsr_write),
    .lfsr_addr(lfsr_addr), .lfsr_din(lfsr_din), .lfsr_enable(lfsr_enable),
    .lfsr_dout(lfsr_dout), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data)
  );

  always #5 clk = ~clk;

  // Eight-step Fibonacci advance: the keystream is seed advanced k times.
  function automatic logic [83:0] adv(input logic [83:0] x);
    logic [83:0] y;
    y = x;
    for (int i = 0; i < 8; i++) y = {y[82:0], y[83] ^ y[82] ^ y[81] ^ y[61]};
    return y;
  endfunction

  // Behavioural LFSR device: enable has priority over a register write.
  logic [83:0] lfsr_q = '0;
  assign lfsr_dout = lfsr_q;
  always @(posedge clk) begin
    if (lfsr_enable) lfsr_q <= adv(lfsr_q);
    else if (lfsr_write) begin
      case (lfsr_addr)
        12'h0a9: lfsr_q[31:0]  <= lfsr_din;
        12'h0aa: lfsr_q[63:32] <= lfsr_din;
        12'h0ab: lfsr_q[83:64] <= lfsr_din[19:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [83:0] seed;
    logic [15:0] nblk;
    int          rmode;      // 0 always ready, 1 random, 2 stall first 5 RUN cycles
    int          abort_cyc;
    int          abort_blk;
    bit          glitch;
    int          exp_blocks;
    int          exp_writes;
    bit          exp_done;
    int          exp_busy;
  } vec_t;

  task automatic run_case(input string tag, input vec_t v);
    int busy_cnt = 0, done_cnt = 0, nblk_got = 0, nwr = 0, prime_en = 0;
    int bad_blk = 0, stab_bad = 0, rule_bad = 0, abort_bad = 0, wr_bad = 0;
    int run_seen = 0, cyc, limit;
    bit held_v = 0, prev_valid = 0, aborting;
    logic [83:0] exp_state, held;
    logic [11:0] wa[3];
    logic [31:0] wd[3];
    logic [31:0] exp_d;
    exp_state = v.seed;
    held = '0;
    limit = 50 + 4 * int'(v.nblk);
    @(posedge clk); #1;
    start = 1'b1; seed = v.seed; num_blocks = v.nblk; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < limit; cyc++) begin
      case (v.rmode)
        0:       ks_ready = 1'b1;
        1:       ks_ready = 1'($urandom_range(0, 1));
        default: ks_ready = (run_seen >= 5);
      endcase
      aborting = (cyc == v.abort_cyc) || (v.abort_blk >= 0 && nblk_got == v.abort_blk && prev_valid);
      abort = aborting;
      if (v.glitch && cyc == 2) begin
        start = 1'b1; seed = ~v.seed; num_blocks = v.nblk + 16'd5;
      end else start = 1'b0;
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (done) done_cnt++;
      if (aborting && (lfsr_write || lfsr_enable || ks_valid)) abort_bad++;
      if (lfsr_write) begin
        if (nwr < 3) begin wa[nwr] = lfsr_addr; wd[nwr] = lfsr_din; end
        nwr++;
        if (lfsr_enable) rule_bad++;
      end else if (lfsr_addr != 12'h0 || lfsr_din != 32'h0) rule_bad++;
      if (held_v && !aborting && !(ks_valid && ks_data == held)) stab_bad++;
      held_v = 0;
      if (ks_valid) begin
        run_seen++;
        if (lfsr_enable !== ks_ready) rule_bad++;
        if (ks_ready) begin
          exp_state = adv(exp_state);
          if (ks_data !== exp_state) bad_blk++;
          nblk_got++;
        end else begin
          held_v = 1; held = ks_data;
        end
      end else if (lfsr_enable) prime_en++;
      prev_valid = ks_valid;
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    checks++;
    if (cyc >= limit) begin
      errors++;
      $display("FAIL %s.timeout cycles=%0d bound=%0d", tag, cyc, limit);
    end
    for (int i = 0; i < 3 && i < nwr; i++) begin
      exp_d = (i == 0) ? v.seed[31:0] : (i == 1) ? v.seed[63:32] : {12'h0, v.seed[83:64]};
      if (wa[i] !== 12'h0a9 + 12'(i) || wd[i] !== exp_d) wr_bad++;
    end
    chk({tag, ".blocks"}, nblk_got, v.exp_blocks);
    chk({tag, ".writes"}, nwr, v.exp_writes);
    chk({tag, ".wdata"}, wr_bad, 0);
    chk({tag, ".done"}, done_cnt, v.exp_done);
    chk({tag, ".prime"}, prime_en, (v.exp_writes == 3) ? 1 : 0);
    chk({tag, ".ksdata"}, bad_blk, 0);
    chk({tag, ".stable"}, stab_bad, 0);
    chk({tag, ".rules"}, rule_bad, 0);
    chk({tag, ".abort"}, abort_bad, 0);
    if (v.exp_busy >= 0) chk({tag, ".busy"}, busy_cnt, v.exp_busy);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vec_t rv;
    logic [95:0] r;
    int n;
    vt[0] = '{84'h1, 16'd3, 0, -1, -1, 1'b0, 3, 3, 1'b1, 8};
    vt[1] = '{84'hA_BCDE_F012_3456_789A_BCDE, 16'd0, 0, -1, -1, 1'b0, 0, 0, 1'b1, 1};
    vt[2] = '{84'h1_2345_6789_ABCD_EF01_2345, 16'd2, 2, -1, -1, 1'b0, 2, 3, 1'b1, 12};
    vt[3] = '{84'hF_0F0F_0F0F_0F0F_0F0F_0F0F, 16'd4, 0, 1, -1, 1'b0, 0, 1, 1'b0, 2};
    vt[4] = '{84'h5_5AA5_1234_0000_FFFF_8001, 16'd4, 0, -1, 1, 1'b0, 1, 3, 1'b0, 6};
    vt[5] = '{84'h9_8765_4321_0FED_CBA9_0001, 16'd3, 0, -1, -1, 1'b1, 3, 3, 1'b1, 8};
    vt[6] = '{84'h3_C3C3_0000_1111_2222_3333, 16'd7, 1, -1, -1, 1'b0, 7, 3, 1'b1, -1};
    vt[7] = '{84'hD_EADB_EEF0_0000_0000_0042, 16'hFFFF, 0, -1, -1, 1'b0, 65535, 3, 1'b1, 65540};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", {busy, done, lfsr_write, lfsr_enable, ks_valid, lfsr_addr, lfsr_din}, '0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_case($sformatf("vec%0d", i), vt[i]);

    // Abort and start together in IDLE: start is dropped
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; seed = 84'h7; num_blocks = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start.busy0", busy, 1'b0);
    @(negedge clk);
    chk("abort_start.busy1", {busy, lfsr_write}, 2'b00);

    // Asynchronous reset during RUN
    @(posedge clk); #1;
    start = 1'b1; seed = 84'h2_4680_1357_9BDF_0246_8ACE; num_blocks = 16'd4; ks_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ks_valid && n < 20);
    chk("rst_run.reached_run", ks_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_run.async_outputs", {busy, done, lfsr_write, lfsr_enable, ks_valid, lfsr_addr, lfsr_din}, '0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_run.idle0", {busy, ks_valid, lfsr_enable}, 3'b000);
    @(negedge clk);
    chk("rst_run.idle1", {busy, ks_valid, lfsr_enable}, 3'b000);
    run_case("after_reset", vt[0]);

    // Randomized runs against the reference model
    for (int k = 0; k < 6; k++) begin
      r = {$urandom, $urandom, $urandom};
      n = $urandom_range(1, 20);
      rv = '{r[83:0], 16'(n), 1, -1, -1, 1'b0, n, 3, 1'b1, -1};
      run_case($sformatf("rand%0d", k), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
